pulse_stretch_mc: RTL and testbench
===================================

Name: pulse_stretch_mc

Overview:
- Multi-channel pulse stretcher in the fast (source) clock domain.
- Converts single-cycle event pulses into fixed-width high windows separated by a guaranteed low gap, so a slow-domain synchronizer samples each event as a distinct level.
- Queues events that arrive while a channel is busy, up to a bounded depth; flags drops with a sticky overflow.
- Sits upstream of the slow-domain multi-stage synchronizer on every fast-to-slow event path.

Parameters:
- CH, 4: number of independent channels.
- HIGH_CYC, 3: clk_fast cycles dout_lvl stays high per event; must be >= 1.
- GAP_CYC, 3: clk_fast cycles dout_lvl stays low between consecutive windows; must be >= 1.
- PEND_W, 2: width of the per-channel pending counter; max queued events = 2^PEND_W-1.

Ports:
- clk_fast  input  1  fast-domain clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din_en  input  CH  event pulses; each cycle a bit is 1 counts as one event on that channel.
- ovf_clr  input  CH  per-channel clear of the ovf flag.
- dout_lvl  output  CH  stretched level toward the slow-domain synchronizer; registered.
- busy  output  CH  channel not IDLE, or pending count nonzero.
- ovf  output  CH  sticky flag: at least one event dropped.

Behaviour:
- Reset (async, rst_n=0): every FSM to IDLE; counters and pending count to 0; dout_lvl=0, busy=0, ovf=0 immediately, without waiting for a clock edge.
- Per-channel FSM states are IDLE, HIGH and GAP. Each channel has its own down-counter, sized $clog2(max(HIGH_CYC,GAP_CYC)+1).
- IDLE with din_en=1: go to HIGH, load the counter with HIGH_CYC. dout_lvl rises the cycle after the event is sampled (latency 1).
- HIGH: dout_lvl=1. When the counter expires after HIGH_CYC cycles, go to GAP and load GAP_CYC.
- GAP: dout_lvl=0. After GAP_CYC cycles:
  - pend>0: decrement pend, go to HIGH.
  - pend=0: go to IDLE.
- Event while in HIGH or GAP:
  - pend < 2^PEND_W-1: increment pend.
  - pend full: event dropped, ovf set.
- Event on the same cycle GAP ends with pend>0: increment and decrement cancel, so pend is unchanged and the FSM goes to HIGH.
- Event on the same cycle GAP ends with pend=0: FSM goes to HIGH directly; pend stays 0.
- Full pend plus a new event on the GAP-end cycle: pend is decremented that cycle, so the event is accepted, not dropped.
- dout_lvl is a pure FSM-state decode from a register; it never glitches.
- busy = (state != IDLE) || (pend != 0); registered-equivalent.
- ovf: set has priority over ovf_clr in the same cycle; otherwise ovf_clr=1 clears it. Clearing ovf does not touch pend.
- Channels are fully independent; there is no arbitration between them.
- Consecutive windows are always exactly HIGH_CYC high and GAP_CYC low. Minimum event period seen downstream = HIGH_CYC+GAP_CYC.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/HIGH/GAP, 2 bits).
  - Counter-width function.
  - Parameter legality checks, asserted at elaboration: HIGH_CYC>=1, GAP_CYC>=1, PEND_W>=1.
- One natural sub-module, pulse_stretch_ch: the single-channel FSM, counter, pending counter and ovf. It is instantiated CH times in a generate loop in pulse_stretch_mc.

Test Plan:
- Reset: assert rst_n=0 mid-simulation with any activity -> dout_lvl=0, busy=0, ovf=0 asynchronously. After release with din_en=0, outputs stay 0.
- Single event: din_en[0]=1 sampled at edge t ->
  - dout_lvl[0]=1 after edges t..t+2, =0 after edges t+3..t+5.
  - busy[0] high from edge t through edge t+5, low after edge t+6.
  - Other channels stay 0.
- Burst of 4 back-to-back events on ch1 (defaults) -> four 3-high/3-low windows (24 cycles total busy), ovf[1]=0. A burst of 5 -> four windows, ovf[1]=1.
- GAP-boundary event: ch2 with pend=1, new event on the final GAP cycle -> pend stays 1, next window starts immediately. Total windows = previous count + 1, no ovf.
- ovf priority: ch3 pend full, drop event with ovf_clr[3]=1 in the same cycle -> ovf[3]=1. ovf_clr[3]=1 alone on the next cycle -> ovf[3]=0.
- Reset mid-HIGH: ch0 in HIGH with pend=2, pulse rst_n low for 1 cycle -> dout_lvl[0]=0 immediately. After release no queued windows replay and busy[0]=0.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel pulse stretcher.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Down-counter must hold the larger of the two window lengths.
  function automatic int cnt_width(input int high_cyc, input int gap_cyc);
    int m;
    m = (high_cyc > gap_cyc) ? high_cyc : gap_cyc;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_ok(input int high_cyc, input int gap_cyc, input int pend_w);
    return (high_cyc >= 1) && (gap_cyc >= 1) && (pend_w >= 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// One stretcher channel: IDLE/HIGH/GAP FSM, window counter, pending-event counter, sticky ovf.
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int HIGH_CYC = 3,
  parameter int GAP_CYC  = 3,
  parameter int PEND_W   = 2
) (
  input  logic              clk_fast,
  input  logic              rst_n,
  input  logic              ev,
  input  logic              clr,
  output state_t            state,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam int                CW       = cnt_width(HIGH_CYC, GAP_CYC);
  localparam logic [CW-1:0]     HIGH_LD  = CW'(HIGH_CYC);
  localparam logic [CW-1:0]     GAP_LD   = CW'(GAP_CYC);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_nxt;
  logic              expire, gap_end, queue_ev, drop;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    expire    = (cnt == CW'(1));
    gap_end   = (state == ST_GAP) && expire;
    // An event on the GAP-end cycle starts the next window directly instead of queueing.
    queue_ev  = ev && (state != ST_IDLE) && !gap_end;
    drop      = queue_ev && (pend == PEND_MAX);
    if (queue_ev && !drop) pend_nxt = pend + 1'b1;

    case (state)
      ST_IDLE: begin
        if (ev) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = HIGH_LD;
        end
      end
      ST_HIGH: begin
        if (expire) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (expire) begin
          if (ev || (pend != '0)) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = HIGH_LD;
            if (!ev) pend_nxt = pend - 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    ovf_nxt = drop | (ovf & ~clr);
  end

endmodule

// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher: independent channels turning event pulses into spaced level windows.
module pulse_stretch_mc
  import pulse_stretch_pkg::*;
#(
  parameter int CH       = 4,
  parameter int HIGH_CYC = 3,
  parameter int GAP_CYC  = 3,
  parameter int PEND_W   = 2
) (
  input  logic          clk_fast,
  input  logic          rst_n,
  input  logic [CH-1:0] din_en,
  input  logic [CH-1:0] ovf_clr,
  output logic [CH-1:0] dout_lvl,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] ovf
);

  if (!params_ok(HIGH_CYC, GAP_CYC, PEND_W)) begin : g_bad_params
    $error("pulse_stretch_mc: HIGH_CYC, GAP_CYC and PEND_W must all be >= 1");
  end

  state_t            ch_state [CH];
  logic [PEND_W-1:0] ch_pend  [CH];

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pulse_stretch_ch #(
      .HIGH_CYC (HIGH_CYC),
      .GAP_CYC  (GAP_CYC),
      .PEND_W   (PEND_W)
    ) u_ch (
      .clk_fast (clk_fast),
      .rst_n    (rst_n),
      .ev       (din_en[i]),
      .clr      (ovf_clr[i]),
      .state    (ch_state[i]),
      .pend     (ch_pend[i]),
      .ovf      (ovf[i])
    );

    // Pure decodes of registered state, so neither output can glitch.
    assign dout_lvl[i] = (ch_state[i] == ST_HIGH);
    assign busy[i]     = (ch_state[i] != ST_IDLE) || (ch_pend[i] != '0);
  end

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Directed bench for pulse_stretch_mc: vector table plus hand-built multi-cycle corner sequences.
module tb_pulse_stretch_mc;

  localparam int CH = 4;

  logic          clk_fast = 1'b0;
  logic          rst_n;
  logic [CH-1:0] din_en;
  logic [CH-1:0] ovf_clr;
  logic [CH-1:0] dout_lvl;
  logic [CH-1:0] busy;
  logic [CH-1:0] ovf;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [CH-1:0] din;
    logic [CH-1:0] clr;
    logic [CH-1:0] dout;
    logic [CH-1:0] bsy;
    logic [CH-1:0] ov;
  } vec_t;

  vec_t vecs[$];

  pulse_stretch_mc #(.CH(CH), .HIGH_CYC(3), .GAP_CYC(3), .PEND_W(2)) dut (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .din_en   (din_en),
    .ovf_clr  (ovf_clr),
    .dout_lvl (dout_lvl),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [CH-1:0] e_dout,
                         input logic [CH-1:0] e_busy, input logic [CH-1:0] e_ovf);
    chk({name, ".dout_lvl"}, dout_lvl, e_dout);
    chk({name, ".busy"}, busy, e_busy);
    chk({name, ".ovf"}, ovf, e_ovf);
  endtask

  // Drive inputs on the falling edge, let one rising edge sample them, then settle before checking.
  task automatic step(input logic [CH-1:0] d, input logic [CH-1:0] c);
    @(negedge clk_fast);
    din_en  = d;
    ovf_clr = c;
    @(posedge clk_fast);
    #1;
  endtask

  task automatic add(input logic [CH-1:0] d, input logic [CH-1:0] c, input logic [CH-1:0] o,
                     input logic [CH-1:0] b, input logic [CH-1:0] v);
    vec_t x;
    x.din = d; x.clr = c; x.dout = o; x.bsy = b; x.ov = v;
    vecs.push_back(x);
  endtask

  // Expected outputs for ch mask m of a train of back-to-back 3-high/3-low windows ending at cycle n.
  function automatic logic [CH-1:0] win(input int c, input int n, input logic [CH-1:0] m);
    return (c < n && (c % 6) < 3) ? m : '0;
  endfunction

  function automatic logic [CH-1:0] upto(input int c, input int n, input logic [CH-1:0] m);
    return (c < n) ? m : '0;
  endfunction

  initial begin
    // Single event on ch0: high after edges 0..2, low 3..5, busy through edge 5.
    for (int c = 0; c < 8; c++)
      add((c == 0) ? 4'b0001 : 4'b0000, 4'b0000, win(c, 3, 4'b0001), upto(c, 6, 4'b0001), 4'b0000);
    // Burst of 4 on ch1: four windows, 24 busy cycles, no drop.
    for (int c = 0; c < 26; c++)
      add((c < 4) ? 4'b0010 : 4'b0000, 4'b0000, win(c, 24, 4'b0010), upto(c, 24, 4'b0010), 4'b0000);
    // Burst of 5 on ch1: fifth event dropped at edge 4.
    for (int c = 0; c < 26; c++)
      add((c < 5) ? 4'b0010 : 4'b0000, 4'b0000, win(c, 24, 4'b0010), upto(c, 24, 4'b0010),
          (c >= 4) ? 4'b0010 : 4'b0000);
    add(4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    rst_n   = 1'b0;
    din_en  = '0;
    ovf_clr = '0;
    #12;
    chk_all("reset_hold", 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk_fast);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(4'b0000, 4'b0000);
      chk_all("post_reset_idle", 4'b0000, 4'b0000, 4'b0000);
    end

    foreach (vecs[i]) begin
      step(vecs[i].din, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].bsy, vecs[i].ov);
    end

    // ch2: pend=1 and a new event on the final GAP cycle (edge 6) -> three windows total.
    for (int c = 0; c < 20; c++) begin
      step((c == 0 || c == 1 || c == 6) ? 4'b0100 : 4'b0000, 4'b0000);
      chk_all($sformatf("gap_end_c%0d", c), win(c, 18, 4'b0100), upto(c, 18, 4'b0100), 4'b0000);
    end

    // ch3: pend full plus an event on the GAP-end cycle is accepted -> five windows, no ovf.
    for (int c = 0; c < 32; c++) begin
      step((c < 4 || c == 6) ? 4'b1000 : 4'b0000, 4'b0000);
      chk_all($sformatf("full_gap_end_c%0d", c), win(c, 30, 4'b1000), upto(c, 30, 4'b1000), 4'b0000);
    end

    // ch3: drop with ovf_clr in the same cycle keeps ovf set; clear alone then wins; pend untouched.
    for (int c = 0; c < 26; c++) begin
      step((c < 5) ? 4'b1000 : 4'b0000, (c == 4 || c == 5) ? 4'b1000 : 4'b0000);
      chk_all($sformatf("ovf_prio_c%0d", c), win(c, 24, 4'b1000), upto(c, 24, 4'b1000),
              (c == 4) ? 4'b1000 : 4'b0000);
    end

    // Reset mid-HIGH: ch0 HIGH with pend=2, ch1 carrying a set ovf.
    for (int c = 0; c < 6; c++)
      step(((c < 5) ? 4'b0010 : 4'b0000) | ((c >= 3) ? 4'b0001 : 4'b0000), 4'b0000);
    chk_all("pre_reset", 4'b0001, 4'b0011, 4'b0010);
    @(negedge clk_fast);
    din_en = '0;
    rst_n  = 1'b0;
    #1;
    chk_all("async_reset", 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk_fast);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(4'b0000, 4'b0000);
      chk_all($sformatf("no_replay_c%0d", c), 4'b0000, 4'b0000, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
